// File: rtl/kgp_prefix_pipe.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : kgp_prefix_pipe
//  Purpose  : 16-bit adder as a 6-stage Kogge-Stone prefix pipeline (5 prefix
//             levels + sum register) with a global stall-all handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module kgp_prefix_pipe (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [16:0] kgp_one,
    input  logic [16:0] kgp_two,
    input  logic [3:0]  in_tag,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] sum,
    output logic        cout,
    output logic        ovf,
    output logic [3:0]  out_tag
);

    localparam int LEVELS = 5;
    localparam int WIDTH  = 17;

    logic                           w_en;
    logic [LEVELS:0]                v_q;
    logic [LEVELS:0]                v_d;

    // Index s holds the registers of stage s+1; P is not needed past level 4.
    logic [LEVELS-1:0][WIDTH-1:0]   g_q;
    logic [LEVELS-1:0][WIDTH-1:0]   g_d;
    logic [LEVELS-2:0][WIDTH-1:0]   p_q;
    logic [LEVELS-2:0][WIDTH-1:0]   p_d;
    logic [LEVELS-1:0][WIDTH-1:0]   w_g_in;
    logic [LEVELS-1:0][WIDTH-1:0]   w_p_in;
    logic [LEVELS-1:0][15:0]        t2_q;
    logic [LEVELS-1:0][3:0]         tag_q;

    logic [15:0]                    sum_q;
    logic                           cout_q;
    logic                           ovf_q;
    logic [3:0]                     out_tag_q;
    logic                           w_unused_p;

    assign w_en     = out_ready | ~v_q[LEVELS];
    assign in_ready = w_en;
    assign v_d      = {v_q[LEVELS-1:0], in_valid};

    generate
        for (genvar s = 0; s < LEVELS; s++) begin : g_level
            localparam int SPAN = 1 << s;
            if (s == 0) begin : g_src_port
                assign w_g_in[s] = kgp_one;
                assign w_p_in[s] = kgp_two;
            end else begin : g_src_reg
                assign w_g_in[s] = g_q[s-1];
                assign w_p_in[s] = p_q[s-1];
            end
            for (genvar i = 0; i < WIDTH; i++) begin : g_pos
                if (i >= SPAN) begin : g_merge
                    assign g_d[s][i] = w_g_in[s][i] | (w_p_in[s][i] & w_g_in[s][i-SPAN]);
                    if (s < LEVELS - 1) begin : g_prop
                        assign p_d[s][i] = w_p_in[s][i] & w_p_in[s][i-SPAN];
                    end
                end else begin : g_pass
                    assign g_d[s][i] = w_g_in[s][i];
                    if (s < LEVELS - 1) begin : g_prop
                        assign p_d[s][i] = w_p_in[s][i];
                    end
                end
            end
        end
    endgenerate

    // Below the top position the last level's propagate never reaches a carry.
    assign w_unused_p = ^w_p_in[LEVELS-1][WIDTH-2:0];

    always_ff @(posedge clk) begin
        if (w_en) begin
            g_q   <= g_d;
            p_q   <= p_d;
            t2_q  <= {t2_q[LEVELS-2:0], kgp_two[16:1]};
            tag_q <= {tag_q[LEVELS-2:0], in_tag};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v_q <= '0;
        end else if (w_en) begin
            v_q <= v_d;
        end
    end

    // Result registers load only for real words so they hold across bubbles.
    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q     <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
            out_tag_q <= '0;
        end else if (w_en && v_q[LEVELS-1]) begin
            sum_q     <= t2_q[LEVELS-1] ^ g_q[LEVELS-1][15:0];
            cout_q    <= g_q[LEVELS-1][16];
            ovf_q     <= g_q[LEVELS-1][15] ^ g_q[LEVELS-1][16];
            out_tag_q <= tag_q[LEVELS-1];
        end
    end

    assign out_valid = v_q[LEVELS];
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign out_tag   = out_tag_q;

endmodule
`default_nettype wire

// File: tb/tb_kgp_prefix_pipe.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_kgp_prefix_pipe
//  Purpose  : Self-checking bench for kgp_prefix_pipe against an arithmetic
//             transaction model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_kgp_prefix_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [16:0] kgp_one;
    logic [16:0] kgp_two;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic [3:0]  out_tag;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [15:0] cur_a;
    logic [15:0] cur_b;
    logic        cur_ci;

    typedef struct {
        logic [3:0]  tag;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        int          at;
    } rec_t;

    rec_t exp_q[$];
    rec_t got_q[$];

    kgp_prefix_pipe dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .kgp_one   (kgp_one),
        .kgp_two   (kgp_two),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    // Expected result of a + b + carry-in, by plain arithmetic.
    function automatic rec_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic ci, input logic [3:0] t, input int at);
        rec_t        r;
        logic [16:0] full;
        int          s;
        full   = {1'b0, a} + {1'b0, b} + {16'd0, ci};
        s      = int'($signed(a)) + int'($signed(b)) + int'(ci);
        r.tag  = t;
        r.sum  = full[15:0];
        r.cout = full[16];
        r.ovf  = (s > 32767) || (s < -32768);
        r.at   = at;
        return r;
    endfunction

    // Transaction monitor: accepted words become expectations, delivered words are captured.
    always @(posedge clk) begin
        if (reset === 1'b1) begin
            exp_q.delete();
        end else begin
            if (out_valid === 1'b1 && out_ready === 1'b1)
                got_q.push_back('{out_tag, sum, cout, ovf, cyc});
            if (in_valid === 1'b1 && in_ready === 1'b1)
                exp_q.push_back(model(cur_a, cur_b, cur_ci, in_tag, cyc));
        end
        cyc++;
    end

    task automatic drive_now(input logic v, input logic [15:0] a, input logic [15:0] b,
                             input logic ci, input logic [3:0] t);
        in_valid = v;
        kgp_one  = {a & b, ci};
        kgp_two  = {a ^ b, 1'b0};
        in_tag   = t;
        cur_a    = a;
        cur_b    = b;
        cur_ci   = ci;
    endtask

    task automatic put(input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic ci, input logic [3:0] t);
        @(negedge clk);
        drive_now(v, a, b, ci, t);
    endtask

    task automatic wait_got(input int n, output bit ok);
        for (int i = 0; i < 300; i++) begin
            if (got_q.size() >= n) break;
            @(negedge clk);
        end
        ok = (got_q.size() >= n) && (exp_q.size() >= n);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        out_ready = 1'b0;
        drive_now(1'b1, 16'h1234, 16'h4321, 1'b0, 4'hF);
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_hs: out_valid=%b in_ready=%b, want 0/1", out_valid, in_ready);
        end
        n_checks++;
        if ({sum, cout, ovf, out_tag} !== 22'd0) begin
            n_fail++;
            $display("FAIL reset_out: sum=%h cout=%b ovf=%b tag=%h, want all 0", sum, cout, ovf, out_tag);
        end
        reset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(negedge clk);
        n_checks++;
        if (got_q.size() != 0) begin
            n_fail++;
            $display("FAIL reset_discard: %0d words out, want 0", got_q.size());
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_directed();
        logic [15:0] va[4]  = '{16'hFFFF, 16'h7FFF, 16'h0000, 16'hFFFF};
        logic [15:0] vb[4]  = '{16'h0001, 16'h0001, 16'h0000, 16'h0000};
        logic        vc[4]  = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [15:0] es[4]  = '{16'h0000, 16'h8000, 16'h0000, 16'h0000};
        logic        eco[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic        eov[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [3:0]  t;
        rec_t        g;
        rec_t        e;
        bit          ok;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            t = 4'(k + 3);
            put(1'b1, va[k], vb[k], vc[k], t);
            put(1'b0, 16'h0, 16'h0, 1'b0, 4'h0);
            wait_got(1, ok);
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL dir_timeout[%0d]: got=%0d, want 1 word", k, got_q.size());
                got_q.delete();
                exp_q.delete();
                continue;
            end
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_checks++;
            if ({g.tag, g.sum, g.cout, g.ovf} !== {t, es[k], eco[k], eov[k]}) begin
                n_fail++;
                $display("FAIL dir_value[%0d]: tag=%h sum=%h cout=%b ovf=%b, want tag=%h sum=%h cout=%b ovf=%b",
                         k, g.tag, g.sum, g.cout, g.ovf, t, es[k], eco[k], eov[k]);
            end
            n_checks++;
            if ({g.sum, g.cout, g.ovf} !== {e.sum, e.cout, e.ovf}) begin
                n_fail++;
                $display("FAIL dir_model[%0d]: sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                         k, g.sum, g.cout, g.ovf, e.sum, e.cout, e.ovf);
            end
            n_checks++;
            if (g.at - e.at != 6) begin
                n_fail++;
                $display("FAIL dir_latency[%0d]: %0d, want 6", k, g.at - e.at);
            end
            n_checks++;
            if (out_valid !== 1'b0 || sum !== es[k] || out_tag !== t) begin
                n_fail++;
                $display("FAIL dir_hold[%0d]: out_valid=%b sum=%h tag=%h, want 0/%h/%h",
                         k, out_valid, sum, out_tag, es[k], t);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] a[8];
        logic [15:0] b[8];
        rec_t        g;
        rec_t        e;
        int          first_at;
        bit          ok;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a[i] = 16'($urandom);
            b[i] = 16'($urandom);
            put(1'b1, a[i], b[i], 1'b0, 4'(i));
        end
        put(1'b0, 16'h0, 16'h0, 1'b0, 4'h0);
        wait_got(8, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL b2b_timeout: got=%0d, want 8 words", got_q.size());
        end else begin
            first_at = got_q[0].at;
            for (int i = 0; i < 8; i++) begin
                g = got_q.pop_front();
                e = exp_q.pop_front();
                n_checks++;
                if (g.tag !== 4'(i) || g.sum !== 16'(a[i] + b[i])) begin
                    n_fail++;
                    $display("FAIL b2b_data[%0d]: tag=%h sum=%h, want tag=%h sum=%h",
                             i, g.tag, g.sum, 4'(i), 16'(a[i] + b[i]));
                end
                n_checks++;
                if ({g.cout, g.ovf} !== {e.cout, e.ovf} || g.at - e.at != 6 || g.at != first_at + i) begin
                    n_fail++;
                    $display("FAIL b2b_flags[%0d]: cout=%b ovf=%b lat=%0d slot=%0d, want %b %b 6 %0d",
                             i, g.cout, g.ovf, g.at - e.at, g.at - first_at, e.cout, e.ovf, i);
                end
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_stall();
        logic [21:0] snap;
        rec_t        g;
        rec_t        e;
        bit          ok;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++)
            put(1'b1, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 4'(8 + i));
        put(1'b1, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 4'd14);
        out_ready = 1'b0;
        #1;
        snap = {sum, cout, ovf, out_tag};
        n_checks++;
        if (out_valid !== 1'b1 || out_tag !== 4'd8) begin
            n_fail++;
            $display("FAIL stall_full: out_valid=%b tag=%h, want 1/8", out_valid, out_tag);
        end
        for (int c = 0; c < 3; c++) begin
            if (c > 0) begin
                @(negedge clk);
                #1;
                n_checks++;
                if ({sum, cout, ovf, out_tag} !== snap) begin
                    n_fail++;
                    $display("FAIL stall_frozen[%0d]: %h, want %h", c, {sum, cout, ovf, out_tag}, snap);
                end
            end
            n_checks++;
            if (in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_in_ready[%0d]: %b, want 0", c, in_ready);
            end
        end
        @(negedge clk);
        #1;
        n_checks++;
        if ({sum, cout, ovf, out_tag} !== snap || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_frozen_end: %h valid=%b, want %h valid=1", {sum, cout, ovf, out_tag}, out_valid, snap);
        end
        out_ready = 1'b1;
        put(1'b1, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 4'd15);
        put(1'b0, 16'h0, 16'h0, 1'b0, 4'h0);
        wait_got(8, ok);
        repeat (4) @(negedge clk);
        n_checks++;
        if (!ok || got_q.size() != 8 || exp_q.size() != 8) begin
            n_fail++;
            $display("FAIL stall_count: got=%0d accepted=%0d, want 8/8", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                g = got_q.pop_front();
                e = exp_q.pop_front();
                n_checks++;
                if ({g.tag, g.sum, g.cout, g.ovf} !== {4'(8 + i), e.sum, e.cout, e.ovf}) begin
                    n_fail++;
                    $display("FAIL stall_data[%0d]: tag=%h sum=%h c=%b v=%b, want tag=%h sum=%h c=%b v=%b",
                             i, g.tag, g.sum, g.cout, g.ovf, 4'(8 + i), e.sum, e.cout, e.ovf);
                end
                n_checks++;
                if (g.at - e.at != ((i < 6) ? 9 : 6)) begin
                    n_fail++;
                    $display("FAIL stall_latency[%0d]: %0d, want %0d", i, g.at - e.at, (i < 6) ? 9 : 6);
                end
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_midstream();
        logic [15:0] a;
        logic [15:0] b;
        rec_t        g;
        rec_t        e;
        bit          ok;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++)
            put(1'b1, 16'($urandom), 16'($urandom), 1'b0, 4'(10 + i));
        @(negedge clk);
        reset = 1'b1;
        drive_now(1'b1, 16'h5555, 16'h5555, 1'b0, 4'd14);
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_hs: out_valid=%b in_ready=%b, want 0/1", out_valid, in_ready);
        end
        a = 16'($urandom);
        b = 16'($urandom);
        drive_now(1'b1, a, b, 1'b0, 4'd5);
        put(1'b0, 16'h0, 16'h0, 1'b0, 4'h0);
        wait_got(1, ok);
        repeat (12) @(negedge clk);
        n_checks++;
        if (!ok || got_q.size() != 1 || exp_q.size() != 1) begin
            n_fail++;
            $display("FAIL midrst_count: got=%0d accepted=%0d, want 1/1", got_q.size(), exp_q.size());
        end else begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_checks++;
            if (g.tag !== 4'd5 || g.sum !== 16'(a + b) || g.at - e.at != 6) begin
                n_fail++;
                $display("FAIL midrst_word: tag=%h sum=%h lat=%0d, want tag=5 sum=%h lat=6",
                         g.tag, g.sum, g.at - e.at, 16'(a + b));
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_random();
        logic [21:0] snap = '0;
        logic        stalled = 1'b0;
        int          n;
        rec_t        g;
        rec_t        e;
        bit          ok;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (stalled) begin
                n_checks++;
                if ({sum, cout, ovf, out_tag} !== snap) begin
                    n_fail++;
                    $display("FAIL rnd_stable[%0d]: %h, want %h", c, {sum, cout, ovf, out_tag}, snap);
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            drive_now(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                      1'($urandom_range(0, 1)), 4'(c));
            #1;
            stalled = out_valid && !out_ready;
            snap = {sum, cout, ovf, out_tag};
        end
        out_ready = 1'b1;
        put(1'b0, 16'h0, 16'h0, 1'b0, 4'h0);
        n = exp_q.size();
        wait_got(n, ok);
        repeat (8) @(negedge clk);
        n_checks++;
        if (!ok || got_q.size() != n) begin
            n_fail++;
            $display("FAIL rnd_count: got=%0d, want %0d", got_q.size(), n);
        end else begin
            for (int i = 0; i < n; i++) begin
                g = got_q.pop_front();
                e = exp_q.pop_front();
                n_checks++;
                if ({g.tag, g.sum, g.cout, g.ovf} !== {e.tag, e.sum, e.cout, e.ovf}) begin
                    n_fail++;
                    $display("FAIL rnd_data[%0d]: tag=%h sum=%h c=%b v=%b, want tag=%h sum=%h c=%b v=%b",
                             i, g.tag, g.sum, g.cout, g.ovf, e.tag, e.sum, e.cout, e.ovf);
                end
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        reset     = 1'b1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        kgp_one   = '0;
        kgp_two   = '0;
        in_tag    = '0;
        cur_a     = '0;
        cur_b     = '0;
        cur_ci    = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_stall();
        test_reset_midstream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/kgp_prefix_pipe.md
KGP_PREFIX_PIPE -- requirements
Module: kgp_prefix_pipe

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 The port list SHALL be, clock and reset first:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous active-high reset
- in_valid  input  1  input word present
- in_ready  output  1  block accepts input this cycle
- kgp_one  input  17  per-position generate (a&b); bit 0 = carry-in slot
- kgp_two  input  17  per-position propagate (a^b); bit 0 = carry-in slot
- in_tag  input  4  opaque tag travelling with the word
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- sum  output  16  adder sum
- cout  output  1  carry out of bit 15
- ovf  output  1  signed overflow
- out_tag  output  4  tag of the result
REQ-003 Position encoding (one,two) SHALL be: (0,0) kill, (1,0) generate, (0,1) propagate; (1,1) SHALL be treated as generate.

Function
REQ-004 The datapath SHALL be a 6-stage registered pipeline: S1..S5 Kogge-Stone prefix levels with span d = 1, 2, 4, 8, 16; S6 sum/output register.
REQ-005 At each level, for position i >= d: G[i] <= G[i] | (P[i] & G[i-d]); P[i] <= P[i] & P[i-d]; for i < d, G[i] and P[i] SHALL pass unchanged.
REQ-006 S1 SHALL take G = kgp_one and P = kgp_two directly from the input ports.
REQ-007 The original kgp_two[16:1] and the tag SHALL travel alongside each stage, unmodified.
REQ-008 S6 SHALL compute sum[i] = kgp_two_orig[i+1] ^ G5[i] for i = 0..15, cout = G5[16], and ovf = G5[15] ^ G5[16].
REQ-009 Each stage S1..S6 SHALL carry a valid bit v1..v6; out_valid = v6.
REQ-010 The global advance enable SHALL be en = out_ready | ~v6, and in_ready SHALL equal en combinationally.
REQ-011 When en = 1, every stage SHALL load from its predecessor, and v1 SHALL load in_valid.
REQ-012 When en = 0, every stage register and valid bit SHALL hold its value.
REQ-013 Bubbles SHALL NOT be compacted; empty stages advance like full ones.
REQ-014 Latency SHALL be 6: a word accepted at edge k SHALL appear on the outputs with out_valid = 1 after edge k+5 when no stall occurs.
REQ-015 Throughput SHALL be one word per cycle while out_ready = 1.
REQ-016 Each stall cycle (out_valid = 1, out_ready = 0) SHALL add exactly one cycle to the latency of every in-flight word.
REQ-017 When in_valid = 0 with en = 1, a bubble SHALL enter the pipeline; the data registers may load, but their values are don't-care.
REQ-018 The outputs sum, cout, ovf and out_tag SHALL be stable while out_valid = 1 and out_ready = 0.
REQ-019 When out_valid = 0, sum, cout, ovf and out_tag SHALL hold their last values.
REQ-020 A non-zero kgp_one[0] SHALL propagate as carry-in through every position (a 17-position prefix).

Reset
REQ-021 Reset SHALL clear v1..v6 to 0 on the next edge, so that out_valid = 0 and in_ready = 1 after that edge.
REQ-022 Reset SHALL clear sum, cout, ovf and out_tag to 0.
REQ-023 Reset SHALL take priority over en and in_valid; a word presented in the reset cycle SHALL be discarded.
REQ-024 Reset asserted mid-stream SHALL drop all in-flight words; no result from those words SHALL appear afterwards.
REQ-025 Internal G and P registers need not be reset.

Verification
REQ-026 The bench SHALL drive a=FFFF, b=0001, tag=3, with out_ready=1 -> after 6 cycles: sum=0000, cout=1, ovf=0, out_tag=3.
REQ-027 The bench SHALL drive a=7FFF, b=0001 -> sum=8000, cout=0, ovf=1; and a=0000, b=0000 -> sum=0000, cout=0, ovf=0.
REQ-028 The bench SHALL drive 8 back-to-back words, tags 0..7, random a/b, with out_ready=1 -> out_valid high for 8 consecutive cycles, tags in order, and sums equal to a+b mod 2^16.
REQ-029 The bench SHALL drop out_ready for 3 cycles while the pipeline is full -> in_ready=0 for those 3 cycles, outputs frozen, no word lost or duplicated, and total latency of each word = 9.
REQ-030 The bench SHALL assert reset for 1 cycle with 4 words in flight -> out_valid=0 the following cycle, none of those tags ever appears, and a new word after reset returns in 6 cycles.
REQ-031 The bench SHALL set kgp_one[0]=1 (carry-in) with a=FFFF, b=0000 -> sum=0000, cout=1.
